ram_priority_arbiter: RTL

Shares the single HyperRAM controller request port among up to four requesters (DMA engine, MMC64 RAM port, future masters) using fixed priority with aging, so a busy DMA transfer cannot starve a slower master indefinitely. It sits between the masters' req/ack ports and the HyperRAM controller, in the system clock domain. It provides the same req/ack port semantics as the existing flat arbitrator.

---
 rtl/ram_priority_arbiter_pkg.sv | 16 +
 rtl/ram_arb_select.sv | 41 ++++
 rtl/ram_priority_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/ram_priority_arbiter_pkg.sv
// Shared definitions for the HyperRAM request-port arbiter: FSM encoding,
// skip-counter width and well-known master indices.
package ram_priority_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_ACK   = 2'd2
   } arb_state_t;

   localparam int SKIP_W = 4;

   localparam int RAM_M_DMA   = 0;
   localparam int RAM_M_MMC64 = 1;

endpackage

// File: rtl/ram_arb_select.sv
// Combinational winner selection: lowest-index promoted master, otherwise
// lowest-index requesting master.
module ram_arb_select
   import ram_priority_arbiter_pkg::*;
#(
   parameter int masters   = 2,
   parameter int max_skips = 7
) (
   input  logic [masters-1:0]        req,
   input  logic [masters*SKIP_W-1:0] skips,
   output logic [1:0]                win,
   output logic                      valid
);

   localparam logic [SKIP_W-1:0] MAX_SK = SKIP_W'(max_skips);

   logic       p_found;
   logic       r_found;
   logic [1:0] p_win;
   logic [1:0] r_win;

   always_comb begin
      p_found = 1'b0;
      r_found = 1'b0;
      p_win   = '0;
      r_win   = '0;
      for (int unsigned i = 0; i < masters; i++) begin
         if (req[i] && !p_found && (skips[i*SKIP_W +: SKIP_W] >= MAX_SK)) begin
            p_win   = 2'(i);
            p_found = 1'b1;
         end
         if (req[i] && !r_found) begin
            r_win   = 2'(i);
            r_found = 1'b1;
         end
      end
      valid = r_found;
      win   = p_found ? p_win : r_win;
   end

endmodule

// File: rtl/ram_priority_arbiter.sv
// Fixed-priority arbiter with aging in front of the single HyperRAM
// controller port; IDLE -> ISSUE -> ACK handshake with registered command.
module ram_priority_arbiter
   import ram_priority_arbiter_pkg::*;
#(
   parameter int masters   = 2,
   parameter int abits     = 24,
   parameter int dbits     = 8,
   parameter int max_skips = 7
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [masters-1:0]       m_req,
   output logic [masters-1:0]       m_ack,
   input  logic [masters-1:0]       m_we,
   input  logic [masters*abits-1:0] m_a,
   input  logic [masters*dbits-1:0] m_d,
   output logic [masters*dbits-1:0] m_q,
   output logic                     s_req,
   input  logic                     s_ack,
   output logic                     s_we,
   output logic [abits-1:0]         s_a,
   output logic [dbits-1:0]         s_d,
   input  logic [dbits-1:0]         s_q,
   output logic [1:0]               grant,
   output logic                     busy
);

   arb_state_t                state;
   logic [masters*SKIP_W-1:0] skips;
   logic [1:0]                win;
   logic                      win_valid;
   logic                      sel_we;
   logic [abits-1:0]          sel_a;
   logic [dbits-1:0]          sel_d;

   ram_arb_select #(
      .masters  (masters),
      .max_skips(max_skips)
   ) u_select (
      .req  (m_req),
      .skips(skips),
      .win  (win),
      .valid(win_valid)
   );

   // Compare-based mux keeps the 2-bit index legal for any master count.
   always_comb begin
      sel_we = 1'b0;
      sel_a  = '0;
      sel_d  = '0;
      for (int unsigned i = 0; i < masters; i++) begin
         if (win == 2'(i)) begin
            sel_we = m_we[i];
            sel_a  = m_a[i*abits +: abits];
            sel_d  = m_d[i*dbits +: dbits];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         skips <= '0;
         m_ack <= '0;
         m_q   <= '0;
         s_req <= 1'b0;
         s_we  <= 1'b0;
         s_a   <= '0;
         s_d   <= '0;
         grant <= '0;
         busy  <= 1'b0;
      end else begin
         m_ack <= '0;
         for (int unsigned i = 0; i < masters; i++) begin
            if (!m_req[i]) skips[i*SKIP_W +: SKIP_W] <= '0;
         end
         case (state)
            ST_IDLE: begin
               if (win_valid) begin
                  s_req <= 1'b1;
                  s_we  <= sel_we;
                  s_a   <= sel_a;
                  s_d   <= sel_d;
                  grant <= win;
                  busy  <= 1'b1;
                  state <= ST_ISSUE;
                  // Losers still requesting age by one, saturating.
                  for (int unsigned i = 0; i < masters; i++) begin
                     if (m_req[i]) begin
                        if (win == 2'(i))
                           skips[i*SKIP_W +: SKIP_W] <= '0;
                        else if (skips[i*SKIP_W +: SKIP_W] != '1)
                           skips[i*SKIP_W +: SKIP_W] <= skips[i*SKIP_W +: SKIP_W] + 1'b1;
                     end
                  end
               end
            end
            ST_ISSUE: begin
               if (s_ack) begin
                  s_req <= 1'b0;
                  for (int unsigned i = 0; i < masters; i++) begin
                     if (grant == 2'(i)) begin
                        m_q[i*dbits +: dbits] <= s_q;
                        m_ack[i]              <= 1'b1;
                     end
                  end
                  state <= ST_ACK;
               end
            end
            ST_ACK: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
